serial_bus_receiver: RTL and testbench

- Receiving end of the shared single-wire data bus. The transmitter drives `data_bus` through a tri-state buffer gated by the active-low `data_enable_low`.
- While the enable is low, this block samples one bit per clock, LSB first, and deserialises the bits into WIDTH-bit words.
- Each completed word is presented on a valid/ready output port for downstream logic.
- The block flags words truncated by an early enable release, and words dropped because the output was still occupied.

---
 rtl/serial_bus_receiver.sv | 102 ++++++++++
 tb/tb_serial_bus_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_receiver.sv
// Single-wire bus receiver: deserialises LSB-first bits into words
// and presents them on a valid/ready port with frame/overrun flags.
module serial_bus_receiver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_enable_low,
  input  logic             data_bus,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  output logic [15:0]      word_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] word;
  logic             xfer;
  logic             can_load;

  assign bit_mask = WIDTH'(1) << cnt;
  assign word     = {data_bus, shreg[WIDTH-2:0]};
  assign xfer     = out_valid & out_ready;
  // slot is free if empty or being drained on this very edge
  assign can_load = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      word_count <= '0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (xfer) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (!data_enable_low) begin
            shreg <= {{(WIDTH-1){1'b0}}, data_bus};
            cnt   <= CNT_W'(1);
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (data_enable_low) begin
            frame_err <= 1'b1;
            shreg     <= '0;
            cnt       <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (cnt == LAST) begin
            shreg <= '0;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (can_load) begin
              out_data   <= word;
              out_valid  <= 1'b1;
              word_count <= word_count + 16'd1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            if (data_bus) begin
              shreg <= shreg | bit_mask;
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_receiver.sv
// Scoreboard bench: queue-based bit model predicts words and flags,
// a negedge monitor compares status and every output transfer.
module tb_serial_bus_receiver;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             busy;
    logic             ferr;
    logic             ovr;
    logic [15:0]      cnt;
  } stat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             data_enable_low = 1'b1;
  logic             data_bus = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             frame_err;
  logic             overrun;
  logic             busy;
  logic [15:0]      word_count;

  serial_bus_receiver #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_enable_low (data_enable_low),
    .data_bus        (data_bus),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .frame_err       (frame_err),
    .overrun         (overrun),
    .busy            (busy),
    .word_count      (word_count)
  );

  always #5 clk = ~clk;

  // reference model state
  logic             bits[$];
  logic             m_full = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic [15:0]      m_cnt = '0;

  logic [WIDTH-1:0] word_q[$];
  stat_t            stat_q[$];

  int total = 0;
  int passed = 0;

  task automatic step(input logic r, input logic en_l,
                      input logic b, input logic rdy);
    logic             ferr;
    logic             ovr;
    logic             load;
    logic             xf;
    logic [WIDTH-1:0] w;
    stat_t            s;
    rst = r;
    data_enable_low = en_l;
    data_bus = b;
    out_ready = rdy;
    ferr = 1'b0;
    ovr = 1'b0;
    load = 1'b0;
    if (r) begin
      bits.delete();
      word_q.delete();
      m_full = 1'b0;
      m_data = '0;
      m_cnt = '0;
    end else begin
      xf = m_full && rdy;
      if (!en_l) begin
        bits.push_back(b);
        if (bits.size() == WIDTH) begin
          w = '0;
          foreach (bits[i]) w[i] = bits[i];
          bits.delete();
          if (!m_full || rdy) begin
            load = 1'b1;
            m_data = w;
            m_cnt = m_cnt + 16'd1;
            word_q.push_back(w);
          end else begin
            ovr = 1'b1;
          end
        end
      end else if (bits.size() != 0) begin
        ferr = 1'b1;
        bits.delete();
      end
      if (load) m_full = 1'b1;
      else if (xf) m_full = 1'b0;
    end
    s.data = m_data;
    s.valid = m_full;
    s.busy = (bits.size() != 0);
    s.ferr = ferr;
    s.ovr = ovr;
    s.cnt = m_cnt;
    stat_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input logic rdy);
    for (int i = 0; i < WIDTH; i++) step(1'b0, 1'b0, w[i], rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, rdy);
  endtask

  task automatic reset_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    stat_t a;
    stat_t e;
    logic [WIDTH-1:0] ew;
    if (stat_q.size() > 0) begin
      e = stat_q.pop_front();
      a = {out_data, out_valid, busy, frame_err, overrun, word_count};
      total++;
      if (a === e) passed++;
      else $display("FAIL status t=%0t got data=%h v=%b busy=%b ferr=%b ovr=%b cnt=%0d want data=%h v=%b busy=%b ferr=%b ovr=%b cnt=%0d",
        $time, a.data, a.valid, a.busy, a.ferr, a.ovr, a.cnt,
        e.data, e.valid, e.busy, e.ferr, e.ovr, e.cnt);
    end
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (word_q.size() == 0) begin
        $display("FAIL xfer t=%0t got %h want <no word pending>",
                 $time, out_data);
      end else begin
        ew = word_q.pop_front();
        if (out_data === ew) passed++;
        else $display("FAIL xfer t=%0t got %h want %h",
                      $time, out_data, ew);
      end
    end
  end

  initial begin
    reset_n(2);
    idle(2, 1'b1);
    // 1: single word 0x4D, bits 1,0,1,1,0,0,1,0
    send(8'h4D, 1'b1);
    idle(3, 1'b1);
    // 2: back-to-back words
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    idle(3, 1'b1);
    // 3: truncated word then full word
    reset_n(1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);
    send(8'hFF, 1'b1);
    idle(3, 1'b1);
    // 4: overrun with downstream stalled
    reset_n(1);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);
    // 5: ready raised on the completing edge
    reset_n(1);
    send(8'h11, 1'b0);
    for (int i = 0; i < WIDTH - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(2, 1'b1);
    // 6: reset in the middle of a word
    reset_n(1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    reset_n(1);
    send(8'h80, 1'b1);
    idle(3, 1'b1);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 99) < 12),
           1'($urandom),
           ($urandom_range(0, 99) < 55));
    end
    idle(4, 1'b1);
    @(negedge clk);
    #1;
    total++;
    if (word_q.size() == 0 && stat_q.size() == 0) passed++;
    else $display("FAIL drain got words=%0d stats=%0d want 0 0",
                  word_q.size(), stat_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
